// File: rtl/apb_mem_ap_if.sv
// APB master bus used by the memory access port.
// master: drives paddr/psel/penable/pwrite/pwdata/pstrb, samples prdata/pready/pslverr.
// slave : the opposite direction, for the bus target or a testbench responder.
interface apb_mem_ap_if;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_mem_ap.sv
// Memory Access Port behind the JTAG debug port. It decodes AP register
// requests (CSW, TAR, DRW, BD0-BD3, CFG, BASE, IDR) and turns DRW/BDx accesses
// into APB transfers, with optional TAR auto-increment inside a 1 KB block.
// Ports:
//   clk, rstn             clock, async active-low reset
//   ap_upd/ap_sel/ap_addr/ap_wdata/ap_rnw  one-cycle request from the DP
//   ap_abort              clears the sticky error, discards an in-flight result
//   ap_busy/ap_rdata/ap_slverr/ap_ack      status and read data back to the DP
//   apb                   APB master bus
//
// state  | meaning
// IDLE   | no transfer; requests accepted
// SETUP  | APB setup phase (psel=1, penable=0)
// ACCESS | APB access phase, waiting for pready
module apb_mem_ap #(
  parameter logic [7:0]  AP_SEL  = 8'h00,
  parameter logic [31:0] AP_IDR  = 32'h0477_0002,
  parameter logic [31:0] AP_BASE = 32'h0000_0003
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ap_upd,
  input  logic [7:0]  ap_sel,
  input  logic [5:0]  ap_addr,
  input  logic [31:0] ap_wdata,
  input  logic        ap_rnw,
  input  logic        ap_abort,
  output logic        ap_busy,
  output logic [31:0] ap_rdata,
  output logic        ap_slverr,
  output logic [2:0]  ap_ack,
  apb_mem_ap_if.master apb
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t      state, state_nxt;
  logic [2:0]  csw_size;
  logic [1:0]  csw_inc;
  logic [31:0] tar;
  logic        xfer_read;
  logic        xfer_drw;
  logic        discard;

  logic        accept;
  logic        is_xfer;
  logic        start;
  logic        done;
  logic        keep;
  logic [31:0] csw_rd;
  logic [31:0] reg_rdata;
  logic [31:0] paddr_nxt;
  logic [3:0]  pstrb_nxt;
  logic [9:0]  tar_step;

  assign accept  = ap_upd && (ap_sel == AP_SEL) && (state == IDLE);
  assign is_xfer = (ap_addr == 6'h03) || (ap_addr[5:2] == 4'b0001);
  assign start   = accept && is_xfer;
  assign done    = (state == ACCESS) && apb.pready;
  // An abort seen during the transfer, or on its completing cycle, drops the result.
  assign keep    = done && !discard && !ap_abort;

  assign ap_busy  = (state != IDLE);
  assign ap_ack   = ap_busy ? 3'h1 : 3'h2;
  assign csw_rd   = {24'h0, ap_busy, 1'b1, csw_inc, 1'b0, csw_size};
  assign tar_step = 10'd1 << csw_size;

  always_comb begin
    reg_rdata = 32'h0;
    case (ap_addr)
      6'h00:   reg_rdata = csw_rd;
      6'h01:   reg_rdata = tar;
      6'h3E:   reg_rdata = AP_BASE;
      6'h3F:   reg_rdata = AP_IDR;
      default: reg_rdata = 32'h0;
    endcase
  end

  always_comb begin
    paddr_nxt = {tar[31:4], ap_addr[1:0], 2'b00};
    pstrb_nxt = 4'hF;
    if (ap_addr == 6'h03) begin
      paddr_nxt = {tar[31:2], 2'b00};
      case (csw_size)
        3'd0:    pstrb_nxt = 4'b0001 << tar[1:0];
        3'd1:    pstrb_nxt = 4'b0011 << {tar[1], 1'b0};
        default: pstrb_nxt = 4'hF;
      endcase
    end
    if (ap_rnw) pstrb_nxt = 4'h0;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (apb.pready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // psel/penable are registered copies of the next state so they are glitch-free.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      apb.psel    <= 1'b0;
      apb.penable <= 1'b0;
    end else begin
      apb.psel    <= (state_nxt != IDLE);
      apb.penable <= (state_nxt == ACCESS);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      csw_size   <= 3'd2;
      csw_inc    <= 2'd0;
      tar        <= 32'h0;
      ap_rdata   <= 32'h0;
      ap_slverr  <= 1'b0;
      xfer_read  <= 1'b0;
      xfer_drw   <= 1'b0;
      discard    <= 1'b0;
      apb.paddr  <= 32'h0;
      apb.pwrite <= 1'b0;
      apb.pwdata <= 32'h0;
      apb.pstrb  <= 4'h0;
    end else begin
      if (accept) begin
        if (is_xfer) begin
          apb.paddr  <= paddr_nxt;
          apb.pstrb  <= pstrb_nxt;
          apb.pwrite <= !ap_rnw;
          apb.pwdata <= ap_wdata;
          xfer_read  <= ap_rnw;
          xfer_drw   <= (ap_addr == 6'h03);
        end else if (ap_rnw) begin
          ap_rdata <= reg_rdata;
        end else if (ap_addr == 6'h00) begin
          csw_size <= (ap_wdata[2:0] > 3'd2) ? 3'd2 : ap_wdata[2:0];
          csw_inc  <= ap_wdata[5:4];
        end else if (ap_addr == 6'h01) begin
          tar <= ap_wdata;
        end
      end else if (ap_upd && (ap_sel != AP_SEL) && (state == IDLE) && ap_rnw) begin
        ap_rdata <= 32'h0;
      end

      if (keep && !apb.pslverr) begin
        if (xfer_read) ap_rdata <= apb.prdata;
        if (xfer_drw && (csw_inc == 2'b01)) tar[9:0] <= tar[9:0] + tar_step;
      end

      if (ap_abort)                    ap_slverr <= 1'b0;
      else if (keep && apb.pslverr)    ap_slverr <= 1'b1;

      if ((state == IDLE) || done) discard <= 1'b0;
      else if (ap_abort)           discard <= 1'b1;
    end
  end

endmodule

// File: tb/tb_apb_mem_ap.sv
module tb_apb_mem_ap;
  logic        clk = 1'b0;
  logic        rstn;
  logic        ap_upd;
  logic [7:0]  ap_sel;
  logic [5:0]  ap_addr;
  logic [31:0] ap_wdata;
  logic        ap_rnw;
  logic        ap_abort;
  logic        ap_busy;
  logic [31:0] ap_rdata;
  logic        ap_slverr;
  logic [2:0]  ap_ack;

  logic [31:0] prdata_drv;
  logic        pready_drv;
  logic        pslverr_drv;

  int n_tests = 0;
  int n_fail  = 0;
  int psel_cycles = 0;
  logic [31:0] last_paddr, last_pwdata;
  logic [3:0]  last_pstrb;
  logic        last_pwrite;

  apb_mem_ap_if bus();
  assign bus.prdata  = prdata_drv;
  assign bus.pready  = pready_drv;
  assign bus.pslverr = pslverr_drv;

  apb_mem_ap dut (
    .clk(clk), .rstn(rstn),
    .ap_upd(ap_upd), .ap_sel(ap_sel), .ap_addr(ap_addr), .ap_wdata(ap_wdata),
    .ap_rnw(ap_rnw), .ap_abort(ap_abort),
    .ap_busy(ap_busy), .ap_rdata(ap_rdata), .ap_slverr(ap_slverr), .ap_ack(ap_ack),
    .apb(bus.master)
  );

  always #5 clk = ~clk;

  // Capture the transfer that completes at the following rising edge.
  always @(negedge clk) begin
    if (bus.psel) psel_cycles++;
    if (bus.psel && bus.penable && pready_drv) begin
      last_paddr  = bus.paddr;
      last_pwdata = bus.pwdata;
      last_pstrb  = bus.pstrb;
      last_pwrite = bus.pwrite;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic ap_req(input logic [7:0] sel, input logic [5:0] addr,
                        input logic [31:0] wd, input logic rnw);
    @(negedge clk);
    ap_upd = 1'b1; ap_sel = sel; ap_addr = addr; ap_wdata = wd; ap_rnw = rnw;
    @(negedge clk);
    ap_upd = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while (ap_busy && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", {31'h0, ap_busy}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ps0;
    rstn = 1'b0; ap_upd = 1'b0; ap_sel = 8'h00; ap_addr = 6'h00; ap_wdata = 32'h0;
    ap_rnw = 1'b0; ap_abort = 1'b0;
    prdata_drv = 32'h0; pready_drv = 1'b1; pslverr_drv = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack",   {29'h0, ap_ack}, 32'h2);
    check("rst_busy",  {31'h0, ap_busy}, 32'h0);
    check("rst_psel",  {31'h0, bus.psel}, 32'h0);
    check("rst_rdata", ap_rdata, 32'h0);
    rstn = 1'b1;

    // Local register reads
    ps0 = psel_cycles;
    ap_req(8'h00, 6'h3F, 32'h0, 1'b1);
    check("idr_rdata", ap_rdata, 32'h0477_0002);
    check("idr_busy",  {31'h0, ap_busy}, 32'h0);
    @(negedge clk);
    check("idr_no_psel", psel_cycles - ps0, 32'd0);
    ap_req(8'h00, 6'h3E, 32'h0, 1'b1);
    check("base_rdata", ap_rdata, 32'h0000_0003);
    ap_req(8'h05, 6'h3F, 32'h0, 1'b1);
    check("sel_mismatch_rdata", ap_rdata, 32'h0);
    ap_req(8'h00, 6'h00, 32'h17, 1'b0);
    ap_req(8'h00, 6'h00, 32'h0, 1'b1);
    check("csw_size_clamp", ap_rdata, 32'h52);

    // Word DRW writes with auto-increment
    ap_req(8'h00, 6'h00, 32'h12, 1'b0);
    ap_req(8'h00, 6'h01, 32'h1000_0000, 1'b0);
    for (int n = 0; n < 4; n++) begin
      ps0 = psel_cycles;
      ap_req(8'h00, 6'h03, 32'hA5A5_0000 + n, 1'b0);
      wait_idle(20);
      check("drw_paddr",  last_paddr, 32'h1000_0000 + 4 * n);
      check("drw_pstrb",  {28'h0, last_pstrb}, 32'hF);
      check("drw_pwrite", {31'h0, last_pwrite}, 32'h1);
      check("drw_pwdata", last_pwdata, 32'hA5A5_0000 + n);
      check("drw_cycles", psel_cycles - ps0, 32'd2);
    end
    ap_req(8'h00, 6'h01, 32'h0, 1'b1);
    check("drw_tar_end", ap_rdata, 32'h1000_0010);

    // Byte DRW read with 1 KB wrap
    ap_req(8'h00, 6'h00, 32'h10, 1'b0);
    ap_req(8'h00, 6'h01, 32'h2000_03FF, 1'b0);
    prdata_drv = 32'hDEAD_BEEF;
    ap_req(8'h00, 6'h03, 32'h0, 1'b1);
    wait_idle(20);
    check("rd_pstrb",  {28'h0, last_pstrb}, 32'h0);
    check("rd_paddr",  last_paddr, 32'h2000_03FC);
    check("rd_pwrite", {31'h0, last_pwrite}, 32'h0);
    check("rd_rdata",  ap_rdata, 32'hDEAD_BEEF);
    ap_req(8'h00, 6'h01, 32'h0, 1'b1);
    check("rd_tar_wrap", ap_rdata, 32'h2000_0000);

    // BD2 write with wait states and an ignored request
    ap_req(8'h00, 6'h01, 32'h3000_0040, 1'b0);
    pready_drv = 1'b0;
    ap_req(8'h00, 6'h06, 32'hCAFE_0002, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        ap_upd = 1'b1; ap_sel = 8'h00; ap_addr = 6'h01; ap_wdata = 32'hFFFF_FFFF; ap_rnw = 1'b0;
      end
      if (i == 2) ap_upd = 1'b0;
      check("bd_wait_busy", {31'h0, ap_busy}, 32'h1);
      check("bd_wait_ack",  {29'h0, ap_ack}, 32'h1);
      @(negedge clk);
    end
    ap_upd = 1'b0;
    pready_drv = 1'b1;
    wait_idle(20);
    check("bd_paddr", last_paddr, 32'h3000_0048);
    check("bd_pstrb", {28'h0, last_pstrb}, 32'hF);
    ap_req(8'h00, 6'h01, 32'h0, 1'b1);
    check("bd_tar", ap_rdata, 32'h3000_0040);

    // Slave error, then abort
    ap_req(8'h00, 6'h00, 32'h12, 1'b0);
    ap_req(8'h00, 6'h01, 32'h4000_0000, 1'b0);
    ap_req(8'h00, 6'h01, 32'h0, 1'b1);
    pslverr_drv = 1'b1; prdata_drv = 32'h1234_5678;
    ap_req(8'h00, 6'h03, 32'h0, 1'b1);
    wait_idle(20);
    pslverr_drv = 1'b0;
    check("err_slverr", {31'h0, ap_slverr}, 32'h1);
    check("err_rdata",  ap_rdata, 32'h4000_0000);
    ap_req(8'h00, 6'h01, 32'h0, 1'b1);
    check("err_tar", ap_rdata, 32'h4000_0000);
    check("err_sticky", {31'h0, ap_slverr}, 32'h1);
    @(negedge clk); ap_abort = 1'b1;
    @(negedge clk); ap_abort = 1'b0;
    check("abort_clear", {31'h0, ap_slverr}, 32'h0);

    // Abort during a transfer discards its read data and increment
    pready_drv = 1'b0; prdata_drv = 32'h55AA_55AA;
    ap_req(8'h00, 6'h03, 32'h0, 1'b1);
    ap_abort = 1'b1;
    @(negedge clk); ap_abort = 1'b0;
    pready_drv = 1'b1;
    wait_idle(20);
    check("abort_rdata", ap_rdata, 32'h4000_0000);
    ap_req(8'h00, 6'h01, 32'h0, 1'b1);
    check("abort_tar", ap_rdata, 32'h4000_0000);

    // Reset in ACCESS
    pready_drv = 1'b0;
    ap_req(8'h00, 6'h03, 32'h0BAD_0000, 1'b0);
    @(negedge clk);
    check("pre_rst_penable", {31'h0, bus.penable}, 32'h1);
    #2 rstn = 1'b0;
    #1;
    check("rst_async_psel",    {31'h0, bus.psel}, 32'h0);
    check("rst_async_penable", {31'h0, bus.penable}, 32'h0);
    check("rst_async_busy",    {31'h0, ap_busy}, 32'h0);
    @(negedge clk);
    rstn = 1'b1; pready_drv = 1'b1;
    ap_req(8'h00, 6'h00, 32'h0, 1'b1);
    check("rst_csw", ap_rdata, 32'h42);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
